// File: rtl/mux2_arb_if.sv
// Handshake bundle for mux2_arb: two requester channels plus the registered output channel.
interface mux2_arb_if #(
  parameter int WIDTH = 4
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
  logic             busy;

  // master: the producers/consumer surrounding the arbiter
  modport master (
    output a_valid, a_data, input a_ready,
    output b_valid, b_data, input b_ready,
    input  out_valid, out_data, sel, busy,
    output out_ready
  );

  modport slave (
    input  a_valid, a_data, output a_ready,
    input  b_valid, b_data, output b_ready,
    output out_valid, out_data, sel, busy,
    input  out_ready
  );
endinterface

// File: rtl/mux2_arb.sv
// Round-robin two-requester arbiter with burst limit feeding one registered output stage.
// Optional per-requester transfer counters (cnt_a/cnt_b) when MUX2_ARB_STATS_EN is defined.
module mux2_arb #(
  parameter int WIDTH = 4,
  parameter int BURST = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mux2_arb_if.slave  bus
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b
`endif
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

  req_t             last;
  req_t             grant;
  logic             grant_valid;
  logic [3:0]       cnt;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  // Stay with the last winner until it has used its burst, then hand over on a tie.
  always_comb begin
    grant_valid = 1'b0;
    grant       = REQ_A;
    if (bus.a_valid && bus.b_valid) begin
      grant_valid = 1'b1;
      if (cnt < 4'(BURST)) begin
        grant = last;
      end else if (last == REQ_A) begin
        grant = REQ_B;
      end else begin
        grant = REQ_A;
      end
    end else if (bus.a_valid) begin
      grant_valid = 1'b1;
      grant       = REQ_A;
    end else if (bus.b_valid) begin
      grant_valid = 1'b1;
      grant       = REQ_B;
    end
  end

  // rst_n gates the readies so nothing is accepted while reset is held.
  always_comb begin
    can_load    = !bus.out_valid || bus.out_ready;
    xfer        = rst_n && can_load && grant_valid;
    bus.a_ready = xfer && (grant == REQ_A);
    bus.b_ready = xfer && (grant == REQ_B);
    mux_data    = (grant == REQ_B) ? bus.b_data : bus.a_data;
    bus.busy    = bus.out_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.sel       <= 1'b0;
      last          <= REQ_B;
      cnt           <= 4'(BURST);
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= mux_data;
      bus.sel       <= (grant == REQ_B);
      if (grant == last) begin
        if (cnt != 4'd15) begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        last <= grant;
        cnt  <= 4'd1;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MUX2_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 8'd0;
      cnt_b <= 8'd0;
    end else if (xfer) begin
      if (grant == REQ_A && cnt_a != 8'd255) begin
        cnt_a <= cnt_a + 8'd1;
      end
      if (grant == REQ_B && cnt_b != 8'd255) begin
        cnt_b <= cnt_b + 8'd1;
      end
    end
  end
`endif

endmodule
